psc_trigger: RTL and testbench



---
 rtl/psc_trigger.sv | 117 +++++++++++
 tb/tb_psc_trigger.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/psc_trigger.sv
// rtl/psc_trigger.sv - EVR trigger to PSC serial trigger frame generator
// Each qualified rising edge of evr_trigger emits one UART-style frame on psc_output.
module psc_trigger #(
  parameter int          CLK_DIV   = 100,
  parameter logic [7:0]  TRIG_CODE = 8'hA5,
  parameter int          PARITY_EN = 0,
  parameter int          STOP_BITS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic evr_trigger,
  output logic psc_output
);

  localparam int              BW       = $clog2(CLK_DIV);
  localparam logic [BW-1:0]   BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [2:0]      STOP_MAX = 3'(STOP_BITS - 1);
  localparam logic            PAR_BIT  = ^TRIG_CODE;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic          s1, s2, s3;
  logic          rise;
  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic          wrap;

  assign wrap = (baud == BAUD_MAX);

  // Two-flop synchroniser plus history flop; the edge pulse is registered
  // so the start bit appears three edges after the first sampling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= evr_trigger;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      psc_output <= 1'b1;
    end else begin
      if (state == IDLE || wrap) baud <= '0;
      else                       baud <= baud + 1'b1;

      case (state)
        IDLE: begin
          bit_idx    <= '0;
          psc_output <= 1'b1;
          if (rise) begin
            state      <= START;
            psc_output <= 1'b0;
          end
        end
        START: begin
          if (wrap) begin
            state      <= DATA;
            bit_idx    <= '0;
            psc_output <= TRIG_CODE[0];
          end
        end
        DATA: begin
          if (wrap) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state      <= PARITY;
                psc_output <= PAR_BIT;
              end else begin
                state      <= STOP;
                psc_output <= 1'b1;
              end
            end else begin
              bit_idx    <= bit_idx + 3'd1;
              psc_output <= TRIG_CODE[bit_idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (wrap) begin
            state      <= STOP;
            bit_idx    <= '0;
            psc_output <= 1'b1;
          end
        end
        STOP: begin
          psc_output <= 1'b1;
          // A rise arriving on the return-to-IDLE edge is seen here and dropped.
          if (wrap) begin
            if (bit_idx == STOP_MAX) begin
              state   <= IDLE;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          psc_output <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psc_trigger.sv
// tb/tb_psc_trigger.sv - self-checking bench for psc_trigger
// Two instances (default and parity/2-stop config) checked every cycle against a frame model.
module tb_psc_trigger;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic trig_d = 1'b0;
  logic trig_p = 1'b0;
  logic out_d, out_p;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  longint e = 0;
  int     cd[2];
  int     flen[2];
  logic   fb[2][12];
  longint last_start[2];
  logic   prev[2];

  always #5 clk = ~clk;

  psc_trigger dut_d (
    .clk(clk), .reset(reset), .evr_trigger(trig_d), .psc_output(out_d)
  );

  psc_trigger #(.CLK_DIV(10), .TRIG_CODE(8'h07), .PARITY_EN(1), .STOP_BITS(2)) dut_p (
    .clk(clk), .reset(reset), .evr_trigger(trig_p), .psc_output(out_p)
  );

  task automatic build_frame(input int i, input int div, input logic [7:0] code,
                             input int par, input int stops);
    int n = 0;
    int ones = 0;
    cd[i] = div;
    fb[i][n] = 1'b0; n++;
    for (int b = 0; b < 8; b++) begin
      fb[i][n] = code[b]; n++;
      if (code[b]) ones++;
    end
    if (par != 0) begin fb[i][n] = ((ones % 2) == 1); n++; end
    for (int s = 0; s < stops; s++) begin fb[i][n] = 1'b1; n++; end
    flen[i] = n * div;
    last_start[i] = -1000000;
    prev[i] = 1'b0;
  endtask

  function automatic logic exp_out(input int i);
    longint d = e - last_start[i];
    if (d >= 0 && d < flen[i]) return fb[i][d / cd[i]];
    return 1'b1;
  endfunction

  // A sampled 0->1 starts a frame 3 edges later unless a frame is still
  // running on that edge (including its final return-to-idle edge).
  task automatic model_edge(input int i, input logic t);
    longint s;
    if (!reset) begin
      prev[i] = 1'b0;
      last_start[i] = -1000000;
    end else begin
      if (t && !prev[i]) begin
        s = e + 3;
        if (s > last_start[i] + flen[i]) last_start[i] = s;
      end
      prev[i] = t;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  task automatic tick();
    logic td, tp;
    td = trig_d;
    tp = trig_p;
    @(posedge clk);
    e++;
    model_edge(0, td);
    model_edge(1, tp);
    #2;
    check("out_def", out_d, exp_out(0));
    check("out_par", out_p, exp_out(1));
    if ($urandom_range(0, 59) == 0) trig_p = ~trig_p;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic async_reset(input int hold);
    reset = 1'b0;
    #1;
    prev[0] = 1'b0; last_start[0] = -1000000;
    prev[1] = 1'b0; last_start[1] = -1000000;
    check("rst_async_def", out_d, 1'b1);
    check("rst_async_par", out_p, 1'b1);
    run(hold);
    reset = 1'b1;
  endtask

  initial begin
    build_frame(0, 100, 8'hA5, 0, 1);
    build_frame(1, 10, 8'h07, 1, 2);

    // Reset held with trigger low: line must stay at mark level.
    reset = 1'b0;
    run(120);
    reset = 1'b1;
    run(1380);

    // Single long pulse: exactly one frame.
    trig_d = 1'b1;
    run(600);
    trig_d = 1'b0;
    run(6500);

    // Second rise mid-frame is ignored.
    trig_d = 1'b1; run(100);
    trig_d = 1'b0; run(100);
    trig_d = 1'b1; run(100);
    trig_d = 1'b0; run(1500);

    // Rise, fall, rise 20 us later: two frames.
    trig_d = 1'b1; run(50);
    trig_d = 1'b0; run(1950);
    trig_d = 1'b1; run(50);
    trig_d = 1'b0; run(1500);

    // Reset during data bit 4, then a full frame after release.
    trig_d = 1'b1; run(20);
    trig_d = 1'b0; run(533);
    async_reset(5);
    run(20);
    trig_d = 1'b1; run(30);
    trig_d = 1'b0; run(1100);

    // Randomised gaps, widths and occasional resets.
    for (int r = 0; r < 25; r++) begin
      run($urandom_range(1, 1300));
      trig_d = 1'b1;
      run($urandom_range(1, 300));
      trig_d = 1'b0;
      if ($urandom_range(0, 9) == 0) async_reset($urandom_range(1, 8));
    end
    run(1100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
